// File: rtl/kbd_con.sv
// PS/2 keyboard receiver: synchronizes ps2_clk/ps2_dat and deframes 11-bit scan-code frames.
// Optional ps2_clk glitch filter enabled by defining KBD_CON_GLITCH_FILTER_EN.
module kbd_con #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_err,
  output logic [2:0] o_err_code,
  output logic       o_busy
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_PARITY  = 3'd1;
  localparam logic [2:0] ERR_START   = 3'd2;
  localparam logic [2:0] ERR_STOP    = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic filt_q, filt_d;
  logic fall;

  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_err_q, par_err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [2:0]    code_q, code_d;

  // Two-flop synchronizers; idle bus level is high
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_dat;
      dat_s2_q <= dat_s1_q;
    end
  end

`ifdef KBD_CON_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic [FW-1:0] flt_cnt_q, flt_cnt_d;

  // A new level is accepted only after FILTER_LEN consecutive differing samples
  always_comb begin
    flt_cnt_d = '0;
    filt_d    = filt_q;
    if (clk_s2_q != filt_q) begin
      if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = clk_s2_q;
      end else begin
        flt_cnt_d = flt_cnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) flt_cnt_q <= '0;
    else       flt_cnt_q <= flt_cnt_d;
  end
`else
  logic unused_filter_len;
  assign unused_filter_len = (FILTER_LEN > 0);

  always_comb begin
    filt_d = clk_s2_q;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) filt_q <= 1'b1;
    else       filt_q <= filt_d;
  end

  assign fall = filt_q & ~filt_d;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    data_d    = data_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    tmo_d     = (state_q == IDLE || fall) ? '0 : tmo_q + TW'(1);

    case (state_q)
      IDLE: begin
        if (fall) begin
          if (dat_s2_q) begin
            err_d  = 1'b1;
            code_d = ERR_START;
          end else begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
      end
      DATA: begin
        if (fall) begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_err_d = ~(^{shift_q, dat_s2_q});
          state_d   = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          if (!dat_s2_q) begin
            err_d  = 1'b1;
            code_d = ERR_STOP;
          end else if (par_err_q) begin
            err_d  = 1'b1;
            code_d = ERR_PARITY;
          end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
            code_d  = ERR_NONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The keyboard stopped clocking mid-frame: abandon it
    if (state_q != IDLE && !fall && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d = IDLE;
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      tmo_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      tmo_q     <= tmo_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      code_q    <= code_d;
    end
  end

  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_err      = err_q;
  assign o_err_code = code_q;
  assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_kbd_con.sv
// Self-checking bench for kbd_con: directed scenarios plus randomized frames against a
// transaction-level expectation queue; glitch scenario runs when KBD_CON_GLITCH_FILTER_EN is defined.
module tb_kbd_con;

  localparam int TMO = 200;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_err;
  logic [2:0] o_err_code;
  logic       o_busy;

  kbd_con #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_err      (o_err),
    .o_err_code (o_err_code),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit       is_err;
    bit [7:0] val;
  } ev_t;

  ev_t        exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_valid  = 0;
  int         n_err    = 0;
  logic [7:0] exp_data = 8'h00;
  logic [2:0] exp_code = 3'd0;
  logic       prev_valid = 1'b0;
  logic       prev_err   = 1'b0;
  int         hp = 15;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Outcome of a complete frame from the protocol rules
  function automatic ev_t frame_outcome(input bit [7:0] d, input bit par, input bit stop);
    ev_t e;
    if (!stop) begin
      e.is_err = 1'b1; e.val = 8'd3;
    end else if ((^{d, par}) != 1'b1) begin
      e.is_err = 1'b1; e.val = 8'd1;
    end else begin
      e.is_err = 1'b0; e.val = d;
    end
    return e;
  endfunction

  function automatic ev_t err_ev(input bit [2:0] code);
    ev_t e;
    e.is_err = 1'b1;
    e.val    = {5'd0, code};
    return e;
  endfunction

  always @(negedge i_clk) begin
    ev_t e;
    if (i_rst) begin
      exp_data = 8'h00;
      exp_code = 3'd0;
      exp_q.delete();
    end else begin
      check("valid_err_exclusive", {31'd0, o_valid & o_err}, 32'd0);
      if (o_valid) begin
        n_valid++;
        check("valid_one_cycle", {31'd0, prev_valid}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("valid_kind", {31'd0, e.is_err}, 32'd0);
          check("valid_data", {24'd0, o_data}, {24'd0, e.val});
          check("valid_code_clear", {29'd0, o_err_code}, 32'd0);
          if (!e.is_err) begin
            exp_data = e.val;
            exp_code = 3'd0;
          end
        end
      end else if (o_err) begin
        n_err++;
        check("err_one_cycle", {31'd0, prev_err}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_err", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("err_kind", {31'd0, e.is_err}, 32'd1);
          check("err_code", {29'd0, o_err_code}, {24'd0, e.val});
          check("err_data_hold", {24'd0, o_data}, {24'd0, exp_data});
          if (e.is_err) exp_code = e.val[2:0];
        end
      end else begin
        check("data_hold", {24'd0, o_data}, {24'd0, exp_data});
        check("code_hold", {29'd0, o_err_code}, {29'd0, exp_code});
      end
    end
    prev_valid = o_valid;
    prev_err   = o_err;
  end

  task automatic send_bit(input bit b);
    @(negedge i_clk);
    ps2_dat = b;
    repeat (hp) @(negedge i_clk);
    ps2_clk = 1'b0;
    repeat (hp) @(negedge i_clk);
    ps2_clk = 1'b1;
  endtask

  // Sends the first nbits bits of a frame (11 = complete frame)
  task automatic send_frame(input bit [7:0] d, input bit par_flip, input bit stop, input int nbits);
    logic [10:0] fr;
    fr = {stop, (~(^d)) ^ par_flip, d, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(fr[i]);
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge i_clk);
    end
    repeat (3) @(negedge i_clk);
    check({name, "_drain"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic good_frame(input bit [7:0] d, input string name);
    exp_q.push_back(frame_outcome(d, ~(^d), 1'b1));
    send_frame(d, 1'b0, 1'b1, 11);
    drain(name, 40);
  endtask

  task automatic pulse_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int v0, e0, kind, cut;
    bit [7:0] d;

    i_rst   = 1'b1;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (4) @(negedge i_clk);
    check("rst_data",  {24'd0, o_data}, 32'd0);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_err",   {31'd0, o_err}, 32'd0);
    check("rst_code",  {29'd0, o_err_code}, 32'd0);
    check("rst_busy",  {31'd0, o_busy}, 32'd0);
    i_rst = 1'b0;
    repeat (4) @(negedge i_clk);

    // Good 0x55
    v0 = n_valid; e0 = n_err;
    good_frame(8'h55, "f55");
    check("f55_nvalid", n_valid - v0, 32'd1);
    check("f55_nerr", n_err - e0, 32'd0);
    check("f55_data", {24'd0, o_data}, 32'h55);
    check("f55_code", {29'd0, o_err_code}, 32'd0);

    // 0x66 with inverted parity
    v0 = n_valid; e0 = n_err;
    exp_q.push_back(err_ev(3'd1));
    send_frame(8'h66, 1'b1, 1'b1, 11);
    drain("f66", 40);
    check("f66_nerr", n_err - e0, 32'd1);
    check("f66_nvalid", n_valid - v0, 32'd0);
    check("f66_code", {29'd0, o_err_code}, 32'd1);
    check("f66_data", {24'd0, o_data}, 32'h55);

    // 0x88 with stop bit 0, then good 0xAA
    e0 = n_err;
    exp_q.push_back(err_ev(3'd3));
    send_frame(8'h88, 1'b0, 1'b0, 11);
    drain("f88", 40);
    check("f88_nerr", n_err - e0, 32'd1);
    check("f88_code", {29'd0, o_err_code}, 32'd3);
    good_frame(8'hAA, "fAA");
    check("fAA_data", {24'd0, o_data}, 32'hAA);
    check("fAA_code", {29'd0, o_err_code}, 32'd0);

    // Clock stops after 4 data bits, then good 0xBB
    e0 = n_err;
    exp_q.push_back(err_ev(3'd4));
    send_frame(8'h3C, 1'b0, 1'b1, 5);
    check("tmo_busy_mid", {31'd0, o_busy}, 32'd1);
    drain("tmo", 3 * TMO);
    check("tmo_nerr", n_err - e0, 32'd1);
    check("tmo_code", {29'd0, o_err_code}, 32'd4);
    check("tmo_busy_after", {31'd0, o_busy}, 32'd0);
    v0 = n_valid;
    good_frame(8'hBB, "fBB");
    check("fBB_nvalid", n_valid - v0, 32'd1);
    check("fBB_data", {24'd0, o_data}, 32'hBB);

    // Reset during data bits of 0xCC, then good 0xDD
    v0 = n_valid; e0 = n_err;
    send_frame(8'hCC, 1'b0, 1'b1, 4);
    check("fCC_busy_mid", {31'd0, o_busy}, 32'd1);
    pulse_reset();
    repeat (2 * TMO) @(negedge i_clk);
    check("fCC_nvalid", n_valid - v0, 32'd0);
    check("fCC_nerr", n_err - e0, 32'd0);
    check("fCC_busy", {31'd0, o_busy}, 32'd0);
    check("fCC_data_rst", {24'd0, o_data}, 32'h00);
    good_frame(8'hDD, "fDD");
    check("fDD_data", {24'd0, o_data}, 32'hDD);

    // Falling edge in IDLE with data high
    e0 = n_err;
    exp_q.push_back(err_ev(3'd2));
    send_bit(1'b1);
    drain("start", 40);
    check("start_nerr", n_err - e0, 32'd1);
    check("start_code", {29'd0, o_err_code}, 32'd2);
    check("start_busy", {31'd0, o_busy}, 32'd0);
    check("start_data", {24'd0, o_data}, 32'hDD);

`ifdef KBD_CON_GLITCH_FILTER_EN
    v0 = n_valid; e0 = n_err;
    @(negedge i_clk);
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    repeat (3) @(negedge i_clk);
    ps2_clk = 1'b1;
    repeat (30) @(negedge i_clk);
    ps2_dat = 1'b1;
    check("glitch_nvalid", n_valid - v0, 32'd0);
    check("glitch_nerr", n_err - e0, 32'd0);
    check("glitch_busy", {31'd0, o_busy}, 32'd0);
    repeat (2 * TMO) @(negedge i_clk);
    check("glitch_nerr_late", n_err - e0, 32'd0);
`endif

    // Randomized frames
    for (int it = 0; it < 60; it++) begin
      hp   = $urandom_range(12, 24);
      d    = 8'($urandom);
      kind = $urandom_range(0, 9);
      case (kind)
        0: begin
          exp_q.push_back(frame_outcome(d, ^d, 1'b1));
          send_frame(d, 1'b1, 1'b1, 11);
          drain("rnd_parity", 40);
        end
        1: begin
          exp_q.push_back(frame_outcome(d, ~(^d) ^ d[0], 1'b0));
          send_frame(d, d[0], 1'b0, 11);
          drain("rnd_stop", 40);
        end
        2: begin
          exp_q.push_back(err_ev(3'd2));
          send_bit(1'b1);
          drain("rnd_start", 40);
        end
        3: begin
          cut = $urandom_range(1, 10);
          exp_q.push_back(err_ev(3'd4));
          send_frame(d, 1'b0, 1'b1, cut);
          drain("rnd_tmo", 3 * TMO);
        end
        4: begin
          cut = $urandom_range(1, 10);
          v0 = n_valid; e0 = n_err;
          send_frame(d, 1'b0, 1'b1, cut);
          pulse_reset();
          repeat (10) @(negedge i_clk);
          check("rnd_rst_pulses", (n_valid - v0) + (n_err - e0), 32'd0);
        end
        default: good_frame(d, "rnd_good");
      endcase
      repeat ($urandom_range(2, 20)) @(negedge i_clk);
    end

    repeat (10) @(negedge i_clk);
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
